// File: rtl/round_robin_weighted_arbiter_pkg.sv
// Shared types and constants for the weighted round-robin arbiter.
// Optional macro: ARB_LOCK_EN (adds a burst lock input).
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // A programmed weight of zero still buys one transfer.
    localparam int MIN_CREDIT = 1;

endpackage

// File: rtl/round_robin_weighted_arbiter_if.sv
// Requester/grant bundle between the clients and the arbiter.
// Optional macro: ARB_LOCK_EN (adds the lock signal).
interface round_robin_weighted_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*WEIGHT_W-1:0] weight;
    logic                        grant_ready;
`ifdef ARB_LOCK_EN
    logic                        lock;
`endif
    logic [NUM_REQ-1:0]          grant;
    logic                        grant_valid;
    logic [IDX_W-1:0]            grant_idx;
    logic                        busy;

`ifdef ARB_LOCK_EN
    modport master (output req, weight, grant_ready, lock,
                    input  grant, grant_valid, grant_idx, busy);
    modport slave  (input  req, weight, grant_ready, lock,
                    output grant, grant_valid, grant_idx, busy);
`else
    modport master (output req, weight, grant_ready,
                    input  grant, grant_valid, grant_idx, busy);
    modport slave  (input  req, weight, grant_ready,
                    output grant, grant_valid, grant_idx, busy);
`endif
endinterface

// File: rtl/round_robin_weighted_arbiter_mask_pick.sv
// Mask/unmask lowest-index picker: prefers requests inside the mask,
// falls back to the full request vector when the masked set is empty.
module rr_mask_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // Choose the pool, isolate its lowest set bit and encode it.
    always_comb begin
        masked = req & mask;
        pool   = (|masked) ? masked : req;
        onehot = pool & (~pool + N'(1));
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
        found  = |req;
    end
endmodule

// File: rtl/round_robin_weighted_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held under a
// valid/ready handshake for up to weight[i] transfers, then rotated.
// Optional macro: ARB_LOCK_EN (lock holds the burst open across transfers).
module round_robin_weighted_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic clk,
    input  logic rst,
    round_robin_weighted_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(MIN_CREDIT);

    arb_state_e           state;
    logic [NUM_REQ-1:0]   mask;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WEIGHT_W-1:0]  credit;

    logic [NUM_REQ-1:0]   rot_mask;
    logic [NUM_REQ-1:0]   pick_mask;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic [WEIGHT_W-1:0]  pick_w;
    logic [WEIGHT_W-1:0]  load_credit;
    logic                 xfer;
    logic                 cur_req;
    logic                 lock_hold;

`ifdef ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign xfer    = (|grant_q) & bus.grant_ready;
    assign cur_req = bus.req[idx_q];

    // Bits strictly above the current grant; the top requester shifts out
    // to an all-zero mask, which forces an unmasked (wrapped) pick.
    assign rot_mask  = ~({grant_q[NUM_REQ-2:0], 1'b0} - NUM_REQ'(1));
    // IDLE picks against the stored pointer, GRANT re-arbitrates as if
    // the current burst had already ended.
    assign pick_mask = (state == ARB_IDLE) ? mask : rot_mask;

    rr_mask_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (bus.req),
        .mask   (pick_mask),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign pick_w      = bus.weight[pick_idx*WEIGHT_W +: WEIGHT_W];
    assign load_credit = (pick_w == '0) ? CREDIT_ONE : pick_w;

    // Arbitration FSM: grant, credit countdown, pointer rotation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            mask    <= '1;
            grant_q <= '0;
            idx_q   <= '0;
            credit  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_oh;
                        idx_q   <= pick_idx;
                        credit  <= load_credit;
                        state   <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (xfer && cur_req && (lock_hold || credit > CREDIT_ONE)) begin
                        if (!lock_hold) credit <= credit - CREDIT_ONE;
                    end else if (xfer) begin
                        // Burst over: the picker prefers others and only
                        // falls back to the same requester when it is alone.
                        mask <= rot_mask;
                        if (pick_found) begin
                            grant_q <= pick_oh;
                            idx_q   <= pick_idx;
                            credit  <= load_credit;
                        end else begin
                            grant_q <= '0;
                            idx_q   <= '0;
                            credit  <= '0;
                            state   <= ARB_IDLE;
                        end
                    end else if (!cur_req) begin
                        mask    <= rot_mask;
                        grant_q <= '0;
                        idx_q   <= '0;
                        credit  <= '0;
                        state   <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.busy        = (state == ARB_GRANT);
endmodule
